// File: rtl/muldiv_pkg.sv
// Shared opcode and FSM state types for the iterative multiply/divide unit.
// The CPU decoder imports op_e from here so both sides agree on encodings.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULH  = 3'd1,
        OP_MULHU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_REM   = 3'd5,
        OP_REMU  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiplier/divider: shift-add multiply, restoring divide,
// sign handled by magnitude conversion at accept and correction at completion.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit FIXED_LAT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             dz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               negRes_q, negRes_d;
    logic               special_q, special_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;

    op_e                opIn;
    logic               isDivIn, isSignedIn, aNeg, bNeg, bZero, ovfIn, specialIn, accept;
    logic [WIDTH-1:0]   aMag, bMag, specialVal;

    function automatic logic isDivOp(input op_e o);
        isDivOp = (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
    endfunction

    // One radix-2 step. Multiply: conditional add into the upper half, shift right.
    // Divide: shift left, trial-subtract the divisor, shift the quotient bit in.
    function automatic logic [2*WIDTH-1:0] iterStep(input logic isDiv,
                                                    input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0] opnd);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] rem;
        logic           ge;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge  = (rem >= {1'b0, opnd});
        if (ge) rem = rem - {1'b0, opnd};
        if (isDiv) iterStep = {rem[WIDTH-1:0], acc[WIDTH-2:0], ge};
        else       iterStep = {sum, acc[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] finalize(input op_e o,
                                                  input logic [2*WIDTH-1:0] acc,
                                                  input logic neg,
                                                  input logic spec);
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   half;
        prod = neg ? -acc : acc;
        half = (o == OP_DIV || o == OP_DIVU) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
        if (neg) half = -half;
        case (o)
            OP_MUL:            finalize = acc[WIDTH-1:0];
            OP_MULH, OP_MULHU: finalize = prod[2*WIDTH-1:WIDTH];
            default:           finalize = half;
        endcase
        if (spec) finalize = acc[WIDTH-1:0];
    endfunction

    assign opIn       = op_e'(op);
    assign isDivIn    = isDivOp(opIn);
    assign isSignedIn = (opIn == OP_MULH) || (opIn == OP_DIV) || (opIn == OP_REM);
    assign aNeg       = isSignedIn & a[WIDTH-1];
    assign bNeg       = isSignedIn & b[WIDTH-1];
    assign aMag       = aNeg ? -a : a;
    assign bMag       = bNeg ? -b : b;
    assign bZero      = (b == '0);
    assign ovfIn      = ((opIn == OP_DIV) || (opIn == OP_REM)) && (a == MIN_NEG) && (b == '1);
    // Divide-by-zero and the reserved op bypass iteration; their answer is known at accept.
    assign specialIn  = (isDivIn & bZero) | (opIn == OP_RSVD);
    assign specialVal = (opIn == OP_DIV || opIn == OP_DIVU) ? '1 :
                        (opIn == OP_RSVD)                   ? '0 : a;
    assign accept     = in_valid & in_ready & ~flush;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        negRes_d  = negRes_q;
        special_d = special_q;
        result_d  = result_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = opIn;
                    cnt_d     = '0;
                    special_d = specialIn;
                    dz_d      = isDivIn & bZero;
                    ovf_d     = ovfIn;
                    negRes_d  = (opIn == OP_REM) ? aNeg : (aNeg ^ bNeg);
                    opnd_d    = isDivIn ? bMag : aMag;
                    acc_d     = {{WIDTH{1'b0}}, (isDivIn ? aMag : bMag)};
                    if (specialIn) acc_d = {{WIDTH{1'b0}}, specialVal};
                    if (specialIn && !FIXED_LAT) begin
                        state_d  = ST_DONE;
                        result_d = specialVal;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // Counter reaching WIDTH means all iterations are in; this edge applies sign fix-up.
                if (cnt_q == CW'(WIDTH)) begin
                    state_d  = ST_DONE;
                    result_d = finalize(op_q, acc_q, negRes_q, special_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!special_q) acc_d = iterStep(isDivOp(op_q), acc_q, opnd_q);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            opnd_q    <= '0;
            acc_q     <= '0;
            negRes_q  <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            negRes_q  <= negRes_d;
            special_q <= special_d;
            result_q  <= result_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized ops
// against an arithmetic reference model, handshake, flush and reset behaviour.
module tb_muldiv_unit;

    localparam int W = 16;
    localparam int SLOW_LAT = W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0, inValid = 1'b0, outReady = 1'b0;
    logic flushF = 1'b0, inValidF = 1'b0, outReadyF = 1'b0;
    logic [2:0] op = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic inReady, outValid, dz, ovf;
    logic inReadyF, outValidF, dzF, ovfF;
    logic [W-1:0] result, resultF;

    int nChecks = 0;
    int nFails = 0;

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         d;
        logic         v;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .FIXED_LAT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(inValid), .in_ready(inReady),
        .op(op), .a(a), .b(b), .out_valid(outValid), .out_ready(outReady),
        .result(result), .dz(dz), .ovf(ovf)
    );

    muldiv_unit #(.WIDTH(W), .FIXED_LAT(1'b0)) dutFast (
        .clk(clk), .rst_n(rst_n), .flush(flushF), .in_valid(inValidF), .in_ready(inReadyF),
        .op(op), .a(a), .b(b), .out_valid(outValidF), .out_ready(outReadyF),
        .result(resultF), .dz(dzF), .ovf(ovfF)
    );

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
    function automatic void refModel(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] r, output logic d, output logic v);
        longint sx, sy, ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        d = 1'b0;
        v = 1'b0;
        p = 0;
        case (o)
            3'd0: p = ux * uy;
            3'd1: p = (sx * sy) >>> W;
            3'd2: p = (ux * uy) >> W;
            3'd3: if (uy == 0) begin p = -1; d = 1'b1; end else p = sx / sy;
            3'd4: if (uy == 0) begin p = -1; d = 1'b1; end else p = ux / uy;
            3'd5: if (uy == 0) begin p = ux; d = 1'b1; end else p = sx % sy;
            3'd6: if (uy == 0) begin p = ux; d = 1'b1; end else p = ux % uy;
            default: p = 0;
        endcase
        if ((o == 3'd3 || o == 3'd5) && sx == -(64'sd1 <<< (W-1)) && sy == -1) v = 1'b1;
        r = p[W-1:0];
    endfunction

    // Presents one request, scrambles inputs after the accepting edge and waits for out_valid.
    // lat counts rising edges after the accepting edge at which out_valid was first seen.
    task automatic doOp(input bit fast, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic d, output logic v,
                        output int lat, output bit timedOut);
        @(negedge clk);
        op = o; a = x; b = y;
        if (fast) inValidF = 1'b1; else inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0; inValidF = 1'b0;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 0;
        timedOut = 1'b0;
        while (!(fast ? outValidF : outValid) && !timedOut) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 60) timedOut = 1'b1;
        end
        r = fast ? resultF : result;
        d = fast ? dzF : dz;
        v = fast ? ovfF : ovf;
    endtask

    task automatic retire(input bit fast);
        @(negedge clk);
        if (fast) outReadyF = 1'b1; else outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0; outReadyF = 1'b0;
    endtask

    task automatic watchQuiet(input int cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (outValid) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
        nChecks++; if (result !== '0) begin nFails++; $display("[TB] FAIL reset_result: got %h expected 0000", result); end
        nChecks++; if (dz !== 1'b0 || ovf !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flags: got dz=%b ovf=%b expected 0/0", dz, ovf); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        nChecks++; if (inReady !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady); end
    endtask

    task automatic test_directed;
        vec_t vecs[11];
        logic [W-1:0] r;
        logic d, v;
        int lat;
        bit to;
        vecs[0]  = '{3'd0, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 16'h00FF, 16'h0101, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{3'd0, 16'hFFFE, 16'h0003, 16'hFFFA, 1'b0, 1'b0};
        vecs[4]  = '{3'd3, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 1'b0};
        vecs[6]  = '{3'd4, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{3'd6, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0};
        vecs[8]  = '{3'd3, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
        vecs[9]  = '{3'd5, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        vecs[10] = '{3'd7, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            doOp(1'b0, vecs[i].o, vecs[i].x, vecs[i].y, r, d, v, lat, to);
            nChecks++;
            if (to || lat != SLOW_LAT) begin nFails++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, SLOW_LAT); end
            nChecks++;
            if (r !== vecs[i].r || d !== vecs[i].d || v !== vecs[i].v) begin
                nFails++;
                $display("[TB] FAIL directed_result[%0d] op=%0d: got %h dz=%b ovf=%b expected %h dz=%b ovf=%b",
                         i, vecs[i].o, r, d, v, vecs[i].r, vecs[i].d, vecs[i].v);
            end
            retire(1'b0);
        end
    endtask

    task automatic test_fast_lat;
        logic [W-1:0] r;
        logic d, v;
        int lat;
        bit to;
        // Early completion means out_valid is already up right after the accepting edge.
        doOp(1'b1, 3'd4, 16'h1234, 16'h0000, r, d, v, lat, to);
        nChecks++; if (to || lat != 0) begin nFails++; $display("[TB] FAIL fast_divu_latency: got %0d expected 0", lat); end
        nChecks++; if (r !== 16'hFFFF || d !== 1'b1) begin nFails++; $display("[TB] FAIL fast_divu_result: got %h dz=%b expected ffff dz=1", r, d); end
        retire(1'b1);
        doOp(1'b1, 3'd6, 16'h1234, 16'h0000, r, d, v, lat, to);
        nChecks++; if (to || lat != 0 || r !== 16'h1234 || d !== 1'b1) begin nFails++; $display("[TB] FAIL fast_remu: got %h dz=%b lat=%0d expected 1234 dz=1 lat=0", r, d, lat); end
        retire(1'b1);
        doOp(1'b1, 3'd7, 16'hABCD, 16'h0005, r, d, v, lat, to);
        nChecks++; if (to || lat != 0 || r !== '0 || d !== 1'b0 || v !== 1'b0) begin nFails++; $display("[TB] FAIL fast_op7: got %h dz=%b ovf=%b lat=%0d expected 0000 0 0 lat=0", r, d, v, lat); end
        retire(1'b1);
        doOp(1'b1, 3'd0, 16'h00FF, 16'h0101, r, d, v, lat, to);
        nChecks++; if (to || lat != SLOW_LAT || r !== 16'hFFFF) begin nFails++; $display("[TB] FAIL fast_mul_full_latency: got %h lat=%0d expected ffff lat=%0d", r, lat, SLOW_LAT); end
        retire(1'b1);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] r, er, x, y;
        logic [2:0] o;
        logic d, v, ed, ev;
        int lat;
        bit to;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 7) == 0) y = '0;
            if ($urandom_range(0, 7) == 0) begin x = 16'h8000; y = 16'hFFFF; end
            refModel(o, x, y, er, ed, ev);
            doOp(1'b0, o, x, y, r, d, v, lat, to);
            nChecks++;
            if (to || lat != SLOW_LAT || r !== er || d !== ed || v !== ev) begin
                nFails++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h dz=%b ovf=%b lat=%0d expected %h dz=%b ovf=%b lat=%0d",
                         i, o, x, y, r, d, v, lat, er, ed, ev, SLOW_LAT);
            end
            retire(1'b0);
        end
    endtask

    task automatic test_hold;
        logic [W-1:0] r;
        logic d, v;
        int lat;
        bit to;
        bit bad;
        doOp(1'b0, 3'd1, 16'h8001, 16'h7FFF, r, d, v, lat, to);
        nChecks++; if (to || r !== 16'hC000) begin nFails++; $display("[TB] FAIL hold_result: got %h expected c000", r); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result !== r || outValid !== 1'b1 || inReady !== 1'b0) bad = 1'b1;
        end
        nChecks++; if (bad) begin nFails++; $display("[TB] FAIL hold_stable: got result=%h valid=%b ready=%b expected %h 1 0", result, outValid, inReady, r); end
        retire(1'b0);
        nChecks++; if (inReady !== 1'b1 || outValid !== 1'b0) begin nFails++; $display("[TB] FAIL hold_release: got ready=%b valid=%b expected 1 0", inReady, outValid); end
    endtask

    task automatic test_flush;
        logic [W-1:0] r, er;
        logic d, v, ed, ev;
        int lat;
        bit to, seen;
        @(negedge clk);
        op = 3'd3; a = 16'h7000; b = 16'h0007; inValid = 1'b1;
        @(posedge clk); #1 inValid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        watchQuiet(30, seen);
        nChecks++; if (seen || inReady !== 1'b1) begin nFails++; $display("[TB] FAIL flush_calc: got valid_seen=%b ready=%b expected 0 1", seen, inReady); end
        @(negedge clk);
        op = 3'd0; a = 16'h0003; b = 16'h0004; inValid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 inValid = 1'b0; flush = 1'b0;
        nChecks++; if (inReady !== 1'b1) begin nFails++; $display("[TB] FAIL flush_idle_block: got ready=%b expected 1", inReady); end
        watchQuiet(25, seen);
        nChecks++; if (seen) begin nFails++; $display("[TB] FAIL flush_idle_quiet: got valid_seen=1 expected 0"); end
        refModel(3'd5, 16'h9ABC, 16'h0123, er, ed, ev);
        doOp(1'b0, 3'd5, 16'h9ABC, 16'h0123, r, d, v, lat, to);
        nChecks++; if (to || r !== er || d !== ed || v !== ev) begin nFails++; $display("[TB] FAIL flush_next_op: got %h expected %h", r, er); end
        retire(1'b0);
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] r, er;
        logic d, v, ed, ev;
        int lat;
        bit to, seen;
        @(negedge clk);
        op = 3'd1; a = 16'h1234; b = 16'h5678; inValid = 1'b1;
        @(posedge clk); #1 inValid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (outValid !== 1'b0 || result !== '0) begin nFails++; $display("[TB] FAIL reset_mid_calc: got valid=%b result=%h expected 0 0000", outValid, result); end
        @(negedge clk) rst_n = 1'b1;
        watchQuiet(25, seen);
        nChecks++; if (seen) begin nFails++; $display("[TB] FAIL reset_mid_calc_quiet: got valid_seen=1 expected 0"); end
        doOp(1'b0, 3'd2, 16'hFFFF, 16'hFFFF, r, d, v, lat, to);
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_in_done: got valid=%b expected 0", outValid); end
        @(negedge clk) rst_n = 1'b1;
        watchQuiet(25, seen);
        nChecks++; if (seen) begin nFails++; $display("[TB] FAIL reset_done_quiet: got valid_seen=1 expected 0"); end
        refModel(3'd3, 16'h8001, 16'h0010, er, ed, ev);
        doOp(1'b0, 3'd3, 16'h8001, 16'h0010, r, d, v, lat, to);
        nChecks++; if (to || lat != SLOW_LAT || r !== er || d !== ed || v !== ev) begin nFails++; $display("[TB] FAIL reset_next_op: got %h lat=%0d expected %h lat=%0d", r, lat, er, SLOW_LAT); end
        retire(1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fast_lat();
        test_back_to_back();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
